// File: rtl/led_pkg.sv
// Shared constants for the LED ripple/trail path.
package led_pkg;

    localparam int unsigned LED_COUNT        = 8;
    localparam int unsigned PWM_BITS_DEFAULT = 4;

    // Full-brightness level for a given PWM width.
    function automatic int unsigned level_max(input int unsigned bits);
        return (32'd1 << bits) - 32'd1;
    endfunction

endpackage

// File: rtl/led_trail_pwm_if.sv
// LED pattern in / PWM drive out between ripple stage and trail stage.
interface led_trail_pwm_if;
    import led_pkg::*;

    logic [LED_COUNT-1:0] led_in;
    logic [LED_COUNT-1:0] led_out;

    modport master (output led_in, input led_out);
    modport slave  (input led_in, output led_out);
endinterface

// File: rtl/led_trail_channel.sv
// One LED channel: brightness level with linear decay and PWM output flop.
module led_trail_channel
    import led_pkg::*;
#(
    parameter int unsigned PWM_BITS = PWM_BITS_DEFAULT
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_bit,
    input  logic                decay_tick,
    input  logic [PWM_BITS-1:0] pcnt,
    output logic                led_out
);

    localparam logic [PWM_BITS-1:0] LVL_MAX = PWM_BITS'(level_max(PWM_BITS));

    logic [PWM_BITS-1:0] lvl;

    // Level: input forces full, otherwise step down on decay tick, saturating at 0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lvl <= '0;
        end else if (in_bit) begin
            lvl <= LVL_MAX;
        end else if (decay_tick && (lvl != '0)) begin
            lvl <= lvl - 1'b1;
        end
    end

    // Output uses the level before this edge's update; input high is a steady on.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            led_out <= 1'b0;
        end else begin
            led_out <= in_bit | (lvl > pcnt);
        end
    end

endmodule

// File: rtl/led_trail_pwm.sv
// Comet-tail LED driver: shared decay prescaler and PWM counter, one channel per LED.
module led_trail_pwm
    import led_pkg::*;
#(
    parameter int unsigned PWM_BITS  = PWM_BITS_DEFAULT,
    parameter int unsigned DECAY_DIV = 65536
) (
    input  logic           clk,
    input  logic           reset,
    led_trail_pwm_if.slave bus
);

    localparam int unsigned DW = (DECAY_DIV > 1) ? $clog2(DECAY_DIV) : 1;
    localparam logic [DW-1:0] DCNT_LAST = DW'(DECAY_DIV - 1);

    logic [DW-1:0]        dcnt;
    logic [PWM_BITS-1:0]  pcnt;
    logic                 decay_tick;
    logic [LED_COUNT-1:0] led_q;

    assign decay_tick = (dcnt == DCNT_LAST);

    // Decay prescaler: 0..DECAY_DIV-1, tick on the last count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dcnt <= '0;
        end else if (decay_tick) begin
            dcnt <= '0;
        end else begin
            dcnt <= dcnt + 1'b1;
        end
    end

    // Free-running PWM phase shared by all channels.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pcnt <= '0;
        end else begin
            pcnt <= pcnt + 1'b1;
        end
    end

    for (genvar i = 0; i < LED_COUNT; i++) begin : g_ch
        led_trail_channel #(
            .PWM_BITS(PWM_BITS)
        ) u_ch (
            .clk       (clk),
            .reset     (reset),
            .in_bit    (bus.led_in[i]),
            .decay_tick(decay_tick),
            .pcnt      (pcnt),
            .led_out   (led_q[i])
        );
    end

    assign bus.led_out = led_q;

endmodule

// File: doc/led_trail_pwm.md
# led_trail_pwm

Downstream stage of the ripple LED generator. Consumes the 8-bit one-hot `led` pattern and drives the physical LEDs with a fading "comet tail". An LED at full brightness while its input bit is high decays linearly to off after the bit drops. Brightness is rendered by a free-running PWM, so the board shows a smooth trail behind the ripple instead of a single hard-switched light.

## Interface
- `PWM_BITS`, default 4: width of the brightness level and of the PWM counter; `LEVEL_MAX` = 2^PWM_BITS − 1.
- `DECAY_DIV`, default 65536: clocks per one-step brightness decrement; legal range ≥ 1.
- `clk`  in  1: single clock; all state on rising edge.
- `reset`  in  1: asynchronous, active-high; one clock; reset is asynchronous and active-high.
- `led_in`  in  8: pattern from ripple stage, synchronous to `clk`, no CDC.
- `led_out`  out  8: PWM-modulated LED drive, registered.

## Operation
- Decay prescaler `dcnt`, width ceil(log2(DECAY_DIV)) (min 1):
  - counts 0..DECAY_DIV−1, then wraps to 0.
  - `decay_tick` is high in the cycle where dcnt == DECAY_DIV−1.
  - With DECAY_DIV = 1, `decay_tick` is high every cycle.
- PWM counter `pcnt`, PWM_BITS wide: free-running, LEVEL_MAX wraps to 0.
- Per channel i, level register `lvl[i]`, PWM_BITS wide, updated each edge in priority order:
  - led_in[i] == 1 → lvl[i] ← LEVEL_MAX. The input wins over a simultaneous decay_tick.
  - else decay_tick && lvl[i] != 0 → lvl[i] ← lvl[i] − 1.
  - else hold. Saturates at 0, never wraps to LEVEL_MAX.
- Output, per channel each edge, using pre-update values: led_out[i] ← led_in[i] | (lvl[i] > pcnt).
  - Input high forces a steady on.
  - Otherwise duty = lvl/2^PWM_BITS; lvl = 0 gives constant off.
- Channels are independent; any number of inputs may be high at once.
- Comparison is unsigned, PWM_BITS wide. No arithmetic wider than PWM_BITS on the level path.

## Timing
- Reset (async assert, clocked release): dcnt = 0, pcnt = 0, lvl[*] = 0, led_out = 8'h00.
  - The reset assertion takes effect immediately, mid-cycle or mid-fade.
  - The first increment of dcnt/pcnt occurs on the first rising edge with reset low.
- Latency led_in[i] rise → led_out[i] high: 1 clock (visible after the same edge that samples it).
- After led_in[i] falls at edge k:
  - lvl[i] = LEVEL_MAX holds until the next decay_tick.
  - Full fade to 0 takes LEVEL_MAX decay_ticks, i.e. at most LEVEL_MAX·DECAY_DIV clocks.
- The PWM period is 2^PWM_BITS clocks. At default parameters on a 1-clock-per-step upstream, flicker is not a concern; frequency choice belongs to the top level.
- dcnt and pcnt are shared by all channels, so fades of channels released on the same edge are cycle-identical.

## Structure
- Shared package `led_pkg`: `LED_COUNT` = 8, default `PWM_BITS`, and the function/constant for `LEVEL_MAX`. The ripple stage also uses `LED_COUNT`.
- Sub-module `led_trail_channel`, instantiated 8× via generate.
  - Inputs: clk, reset, in bit, decay_tick, pcnt.
  - Contents: the lvl register and the led_out flop.
- The top holds only the dcnt prescaler and the pcnt counter.

## Test plan
Parameters for scenarios 1–5: DECAY_DIV = 4, PWM_BITS = 4; scenario 6 uses DECAY_DIV = 1024.
1. **Reset mid-fade:** drive led_in = 8'hFF for 10 cycles, drop to 0, assert reset for 3 ns between edges → led_out = 8'h00 immediately; all lvl = 0; after release, led_out stays 0.
2. **Single pulse:** led_in[0] high for 1 cycle → led_out[0] high the next cycle. lvl[0] decrements once per 4 clocks, reaches 0 after exactly 15 decay_ticks, then stays 0 (no wrap to 15); led_out[0] then constantly 0.
3. **Simultaneous input and decay:** hold led_in[3] high across a decay_tick edge → lvl[3] stays 15; led_out[3] stays 1 every cycle.
4. **Ripple trail:** drive a one-hot pattern walking 8'h01→8'h80, one step per 16 clocks → each led_out[i] is solid while its input is high. Previous channels show decreasing PWM duty with strictly ordered levels lvl[i−1] > lvl[i−2]; no channel ever exceeds LEVEL_MAX.
5. **All on:** led_in = 8'hFF held for 200 cycles → led_out = 8'hFF every cycle; lvl all 15.
6. **Duty check (DECAY_DIV = 1024):** pulse led_in[5], then observe one full 16-cycle PWM window before the first decay_tick → led_out[5] high exactly 15 of 16 cycles, low only when pcnt == 15.
